// File: rtl/trng_key_arbiter.sv
// TRNG key collector: warms up the entropy core, buffers its keys in a small FIFO and hands them out round-robin.
// Grant and key are combinational in the request cycle; the core is held (no ack) while the buffer is full.
module trng_key_arbiter #(
   parameter int N_REQ         = 2,
   parameter int KEY_W         = 32,
   parameter int FIFO_DEPTH    = 4,
   parameter int WARMUP_CYCLES = 64
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          en_i,
   input  logic                          flush_i,
   output logic                          trng_enable_o,
   output logic                          trng_ack_read_o,
   input  logic                          trng_key_ready_i,
   input  logic [KEY_W-1:0]              trng_key_i,
   input  logic [N_REQ-1:0]              req_i,
   output logic [N_REQ-1:0]              gnt_o,
   output logic [KEY_W-1:0]              key_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic                          ready_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(WARMUP_CYCLES + 1);

   localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARMUP_CYCLES - 1);
   localparam logic [IDX_W-1:0] RR_RST    = IDX_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WARMUP  = 2'd1,
      COLLECT = 2'd2,
      ACK     = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [IDX_W-1:0] rr_q, rr_d;
   logic [KEY_W-1:0] mem_q [FIFO_DEPTH];

   logic             accept;
   logic             push;
   logic             pop;
   logic             found;
   logic [IDX_W-1:0] gnt_idx;
   int               cand;

   // ---------------------------------------------------------------
   // Controller FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (en_i) begin
               state_d = WARMUP;
               cnt_d   = WARM_LOAD;
            end
         end
         WARMUP: begin
            if (!en_i) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d = COLLECT;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         COLLECT: begin
            // Never take a key we cannot acknowledge, or the core would offer it again.
            if (!en_i) begin
               state_d = IDLE;
            end else if (trng_key_ready_i && (level_q != FULL_LVL)) begin
               accept  = 1'b1;
               state_d = ACK;
            end
         end
         ACK: begin
            state_d = en_i ? COLLECT : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A flushed key is still acknowledged but never stored.
   assign push = accept && !flush_i;

   // ---------------------------------------------------------------
   // Round-robin arbiter
   // ---------------------------------------------------------------
   always_comb begin
      found   = 1'b0;
      gnt_idx = rr_q;
      cand    = 0;
      for (int off = 1; off <= N_REQ; off++) begin
         cand = int'(rr_q) + off;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         if (!found && req_i[cand]) begin
            found   = 1'b1;
            gnt_idx = cand[IDX_W-1:0];
         end
      end
   end

   assign pop   = found && (level_q != '0) && !flush_i;
   assign gnt_o = pop ? (N_REQ'(1) << gnt_idx) : '0;
   assign rr_d  = pop ? gnt_idx : rr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q <= RR_RST;
      end else begin
         rr_q <= rr_d;
      end
   end

   // ---------------------------------------------------------------
   // Key FIFO
   // ---------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= trng_key_i;
      end
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   assign trng_enable_o   = (state_q != IDLE);
   assign trng_ack_read_o = (state_q == ACK);
   assign ready_o         = (state_q == COLLECT) || (state_q == ACK);
   assign level_o         = level_q;
   assign key_o           = mem_q[rd_ptr_q];

endmodule
